// File: rtl/stopwatch_ctrl_if.sv
// Button/counter/display signal bundle around the stopwatch sequencer.
// The bench or fabric drives through master; the controller sits on slave.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap_clr;
  logic [3:0] ones_in;
  logic [3:0] tens_in;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output start_stop, lap_clr, ones_in, tens_in,
    input  cnt_en, cnt_clr, disp_ones, disp_tens, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap_clr, ones_in, tens_in,
    output cnt_en, cnt_clr, disp_ones, disp_tens, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/pause/lap/clear FSM, tick prescaler and
// lap-freeze display mux sitting in front of an external 2-digit BCD counter.
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 10,
  parameter int STOP_AT_MAX = 1
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.slave   sw
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP, FULL} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [3:0]    lap_ones, lap_tens;
  logic          clr_q, ovf_q;
  logic          active, tick, at_max, term_stop, en;
  logic          cap, clr_go, ovf_set;

  assign active    = (state == RUN) || (state == LAP);
  assign tick      = active && (pre == LAST);
  assign at_max    = (sw.ones_in == 4'd9) && (sw.tens_in == 4'd9);
  // In halt mode the 99 tick is swallowed and turned into the FULL transition.
  assign term_stop = tick && at_max && (STOP_AT_MAX != 0);
  assign en        = tick && !term_stop;

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    cap       = 1'b0;
    clr_go    = 1'b0;
    ovf_set   = en && at_max && (STOP_AT_MAX == 0);
    if (active && !term_stop)
      pre_nxt = (pre == LAST) ? '0 : pre + 1'b1;
    // start_stop is tested first in each state so it wins over lap_clr.
    unique case (state)
      IDLE:  if (sw.start_stop) state_nxt = RUN;
      RUN: begin
        if (sw.start_stop)   state_nxt = PAUSE;
        else if (sw.lap_clr) begin state_nxt = LAP; cap = 1'b1; end
        else if (term_stop)  state_nxt = FULL;
      end
      LAP: begin
        if (sw.start_stop)   state_nxt = PAUSE;
        else if (sw.lap_clr) state_nxt = RUN;
        else if (term_stop)  state_nxt = FULL;
      end
      PAUSE: begin
        if (sw.start_stop)   state_nxt = RUN;
        else if (sw.lap_clr) begin state_nxt = IDLE; clr_go = 1'b1; end
      end
      FULL:  if (sw.lap_clr) begin state_nxt = IDLE; clr_go = 1'b1; end
      default: state_nxt = IDLE;
    endcase
    if (clr_go) pre_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pre      <= '0;
      lap_ones <= '0;
      lap_tens <= '0;
      clr_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      clr_q <= clr_go;
      if (cap) begin
        lap_ones <= sw.ones_in;
        lap_tens <= sw.tens_in;
      end
      if (clr_go)       ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign sw.cnt_en     = en;
  assign sw.cnt_clr    = clr_q;
  assign sw.running    = active;
  assign sw.lap_active = (state == LAP);
  assign sw.overflow   = ovf_q;
  assign sw.disp_ones  = (state == LAP) ? lap_ones : sw.ones_in;
  assign sw.disp_tens  = (state == LAP) ? lap_tens : sw.tens_in;
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the 2-digit BCD counter (ones/tens, 0-99), turning that counter into a stopwatch.
- Takes debounced single-cycle button pulses and runs a start/pause/lap/clear state machine.
- Prescales the system clock into counter-enable ticks and generates the counter clear.
- Selects live or frozen-lap digits for the display.
- Sits between the button debouncers, the counter and the 7-segment driver.

Parameters:
TICK_DIV, 10, clock cycles per counter increment (>=2); the bench uses 4.
STOP_AT_MAX, 1, 1 = halt at 99 (FULL state); 0 = wrap 99->00 and set the sticky overflow flag.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start_stop  input  1  one-cycle pulse, start/pause toggle
lap_clr  input  1  one-cycle pulse, lap freeze/release or clear
ones_in  input  4  counter ones digit (BCD 0-9)
tens_in  input  4  counter tens digit (BCD 0-9)
cnt_en  output  1  one-cycle increment enable to the counter
cnt_clr  output  1  one-cycle synchronous clear to the counter
disp_ones  output  4  ones digit to the display
disp_tens  output  4  tens digit to the display
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky, set on 99->00 wrap (STOP_AT_MAX=0 only)

Behaviour:
- Reset (async):
  - state=IDLE, prescaler=0, lap regs=0, overflow=0, cnt_clr=0.
  - cnt_en=0; disp_* shows the live inputs.
- States: IDLE, RUN, PAUSE, LAP, FULL. Encoding is free.
- Button priority: if start_stop and lap_clr arrive in the same cycle, start_stop wins and lap_clr is dropped.
- Transitions:
  - IDLE: start_stop->RUN. lap_clr ignored.
  - RUN: start_stop->PAUSE. lap_clr->LAP, capturing ones_in/tens_in into the lap regs at that edge.
  - LAP: lap_clr->RUN (display released). start_stop->PAUSE (display reverts to live).
  - PAUSE: start_stop->RUN. lap_clr->IDLE; cnt_clr=1 for exactly the next cycle; prescaler->0; overflow->0.
  - FULL: lap_clr->IDLE, same clear actions as PAUSE->IDLE. start_stop ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN/LAP, wrapping to 0.
  - Holds its value in PAUSE/FULL, so resume keeps sub-tick phase.
  - Zeroed on entry to IDLE.
- cnt_en:
  - Combinational: 1 when state in {RUN,LAP} and prescaler==TICK_DIV-1, unless suppressed as below.
  - The counter increments on the following edge.
  - First tick comes TICK_DIV cycles after the start_stop edge.
- Terminal count: when cnt_en would assert with ones_in==9 and tens_in==9:
  - STOP_AT_MAX=1: cnt_en suppressed, next state FULL (from RUN or LAP), prescaler held.
  - STOP_AT_MAX=0: cnt_en asserted; overflow set at that edge and held until IDLE entry or reset.
- Button vs tick in the same cycle: a button edge out of RUN/LAP does not suppress the cnt_en of that cycle; the tick still counts.
- Display: disp_* = lap regs when state==LAP, else ones_in/tens_in. Combinational mux.
- running and lap_active are decoded from the state register.
- Inputs ones_in/tens_in are trusted BCD; no range checking.
- Reset mid-run: immediate return to IDLE values. No cnt_clr is issued; the counter has its own reset.

Test Plan:
1. TICK_DIV=4: reset, pulse start_stop -> running=1; cnt_en pulses on cycles 4, 8, 12 after start; a counter model reads 03 after 12 cycles.
2. Run to count 07, pulse lap_clr -> lap_active=1, disp=07 frozen while the live count reaches 10. Pulse lap_clr -> disp follows live (10+).
3. Run, start_stop at count 05 with prescaler=2 -> PAUSE, no cnt_en for 20 cycles. start_stop -> next cnt_en after 1 cycle. lap_clr in PAUSE -> cnt_clr one cycle, state IDLE, digits 00.
4. STOP_AT_MAX=1, count reaches 99 -> no further cnt_en, running=0; start_stop ignored; lap_clr -> cnt_clr, IDLE.
5. STOP_AT_MAX=0, count reaches 99 -> next tick cnt_en=1, counter 00, overflow=1 sticky; pause+lap_clr -> overflow=0.
6. start_stop and lap_clr in the same cycle while in RUN -> PAUSE, no lap capture. Assert reset mid-LAP -> all outputs at reset values asynchronously, before the next clock edge.
